regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (we/wa/wd) between two writeback sources. Requester A is the in-order pipeline writeback: fixed priority, zero latency, normally never stalled. Requester B is a long-latency unit (mul/div, or a slow load path) with a valid/ready handshake and a small FIFO. The block exports a pending-write mask so decode can interlock on registers with queued B writes, and it can briefly stall A to prevent B starvation.

Parameters:
DEPTH, 4, B-queue entries; power of 2, at least 2.
MAX_WAIT, 8, cycles a non-empty B head may wait before A is stalled (starvation guard only).

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
a_we  input  1  pipeline writeback request
a_wa  input  5  pipeline destination register
a_wd  input  32  pipeline write data
stall_a  output  1  pipeline must hold a_* stable and freeze this cycle
b_valid  input  1  long-latency unit has a result
b_wa  input  5  B destination register
b_wd  input  32  B write data
b_ready  output  1  B result accepted at this posedge when b_valid=1
rf_we  output  1  to regfile we
rf_wa  output  5  to regfile wa
rf_wd  output  32  to regfile wd
pending_mask  output  32  bit r=1 iff a queued B entry targets register r
b_count  output  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst=1 at posedge): queue emptied, read and write pointers 0, wait counter 0. While rst=1: rf_we=0, b_ready=0, stall_a=0. Queued entries are discarded when reset is asserted mid-operation.
- A is valid iff a_we=1 and a_wa!=0. Requests to register 0 produce no write and no stall.
- Grant A when A is valid and stall_a=0. In the same cycle (combinational): rf_we=1, rf_wa=a_wa, rf_wd=a_wd.
- Grant B head when the queue is non-empty and A is not granted. Then rf_we=1, rf_wa=head.wa, rf_wd=head.wd, and the head is popped at the posedge.
- No grant: rf_we=0. rf_wa and rf_wd are driven to 0.
- b_ready = !full and !rst. It is not affected by a same-cycle pop, so a full queue refuses B even while it is draining.
- Enqueue happens at the posedge when b_valid and b_ready are both 1. An accepted entry with b_wa=0 is dropped and not stored.
- Minimum B latency is 1 cycle: acceptance at edge N, earliest port write in cycle N+1. B input never bypasses the queue.
- Simultaneous push and pop: occupancy stays the same and both pointers advance, wrapping modulo DEPTH.
- B entries leave the queue in FIFO order.
- pending_mask is combinational, the OR of one-hot(wa) over valid entries. A popped entry's bit clears after the pop edge unless another entry targets the same register.
- WAW ordering is not resolved here. Decode must stall any instruction whose destination or source has its pending_mask bit set.
- The regfile's write-first bypass makes the granted write visible on read ports in the same cycle.

Optional Feature:
WB_STARVE_GUARD_EN
- Defined:
  - wait_cnt increments each cycle the queue is non-empty and the head is not granted.
  - wait_cnt clears on a B grant, when the queue is empty, or on reset.
  - stall_a = (wait_cnt == MAX_WAIT).
  - While stall_a=1, A is not granted and the head is granted; wait_cnt then clears, so stall_a lasts exactly 1 cycle.
  - The pipeline re-presents A in the next cycle.
- Undefined: no counter exists, stall_a is tied to 0, and B is serviced only in cycles where A is idle. B may starve indefinitely.

Test Plan:
1. Reset with rst=1 for 2 cycles while a_we=1, a_wa=5, b_valid=1 -> rf_we=0, b_ready=0, b_count=0, pending_mask=0.
2. Only A active: a_we=1, a_wa=3, a_wd=0xDEADBEEF -> same cycle rf_we=1, rf_wa=3, rf_wd=0xDEADBEEF. Repeat with a_wa=0 -> rf_we=0.
3. B push of wa=7, wd=0x11 with A idle:
   - After the push edge: pending_mask=0x80, b_count=1.
   - Next cycle: rf_we=1, rf_wa=7, rf_wd=0x11.
   - After the pop edge: pending_mask=0, b_count=0.
4. Fill with DEPTH=4 pushes (wa 1,2,3,4) while A writes every cycle:
   - b_ready=0 and b_count=4; a fifth b_valid is not accepted.
   - Release A -> writes in order 1,2,3,4 on consecutive cycles, and b_ready returns to 1 after the first pop edge.
5. Simultaneous A valid (wa=9) and non-empty queue (head wa=10) -> port writes 9 and the head stays. The next A-idle cycle writes 10.
6. With WB_STARVE_GUARD_EN, MAX_WAIT=8, A writing every cycle and one queued B entry:
   - stall_a=1 in exactly the 9th cycle after enqueue, and the head is written that cycle.
   - The next cycle has stall_a=0 and A is granted.
   - Without the macro, stall_a stays 0 and the entry stays queued.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Desc     : Shares the register-file write port between the in-order pipeline
//            writeback (A, fixed priority) and a FIFO-queued long-latency
//            source (B). Optional macro WB_STARVE_GUARD_EN adds a one-cycle
//            stall of A when the B head has waited MAX_WAIT cycles.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_we,
    input  logic [4:0]             a_wa,
    input  logic [31:0]            a_wd,
    output logic                   stall_a,
    input  logic                   b_valid,
    input  logic [4:0]             b_wa,
    input  logic [31:0]            b_wd,
    output logic                   b_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_wa,
    output logic [31:0]            rf_wd,
    output logic [31:0]            pending_mask,
    output logic [$clog2(DEPTH):0] b_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_param_check
        $error("regfile_wb_arbiter: DEPTH must be a power of 2 >= 2, MAX_WAIT >= 1");
    end

    logic [4:0]         r_q_wa [DEPTH];
    logic [31:0]        r_q_wd [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [c_ptr_w-1:0] w_slot;
    logic               w_empty;
    logic               w_full;
    logic               w_a_valid;
    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_push;

    assign w_empty   = (r_count == '0);
    // Occupancy never exceeds DEPTH, a power of 2, so the MSB alone flags full.
    assign w_full    = r_count[c_ptr_w];
    assign w_a_valid = a_we && (a_wa != 5'd0);
    assign b_ready   = !w_full && !rst;
    assign w_push    = b_valid && b_ready && (b_wa != 5'd0);
    assign w_grant_a = w_a_valid && !stall_a && !rst;
    assign w_grant_b = !w_empty && !w_grant_a && !rst;
    assign b_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_wa[r_wr_ptr] <= b_wa;
            r_q_wd[r_wr_ptr] <= b_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant_b) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_grant_b})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        if (w_grant_a) begin
            rf_we = 1'b1;
            rf_wa = a_wa;
            rf_wd = a_wd;
        end else if (w_grant_b) begin
            rf_we = 1'b1;
            rf_wa = r_q_wa[r_rd_ptr];
            rf_wd = r_q_wd[r_rd_ptr];
        end
    end

    // Slot i holds a live entry when its distance from the head is below occupancy.
    always_comb begin
        pending_mask = '0;
        w_slot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = c_ptr_w'(i) - r_rd_ptr;
            if ({1'b0, w_slot} < r_count) begin
                pending_mask[r_q_wa[i]] = 1'b1;
            end
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int                  c_wait_w   = $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_max_wait = MAX_WAIT[c_wait_w-1:0];

    logic [c_wait_w-1:0] r_wait_cnt;

    // Reaching MAX_WAIT forces a B grant, which clears the count: no saturation needed.
    always_ff @(posedge clk) begin
        if (rst || w_empty || w_grant_b) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign stall_a = !rst && (r_wait_cnt == c_max_wait);
`else
    assign stall_a = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// Testbench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        stall_a;
    logic        b_valid;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pending_mask;
    logic [2:0]  b_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd), .stall_a(stall_a),
        .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pending_mask(pending_mask), .b_count(b_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: B queue as SV queues plus a waiting-cycle count.
    logic [4:0]  m_wa[$];
    logic [31:0] m_wd[$];
    int          m_wait = 0;

    logic        e_stall, e_ready, e_we, e_bgrant;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_mask;
    logic [2:0]  e_count;

    function automatic void model_outputs();
        bit a_ok;
        a_ok     = a_we && (a_wa != 5'd0);
        e_stall  = GUARD && !rst && (m_wait == MAX_WAIT);
        e_ready  = !rst && (m_wa.size() < DEPTH);
        e_we     = 1'b0;
        e_wa     = 5'd0;
        e_wd     = 32'd0;
        e_bgrant = 1'b0;
        if (!rst && a_ok && !e_stall) begin
            e_we = 1'b1; e_wa = a_wa; e_wd = a_wd;
        end else if (!rst && m_wa.size() > 0) begin
            e_we = 1'b1; e_wa = m_wa[0]; e_wd = m_wd[0]; e_bgrant = 1'b1;
        end
        e_mask = 32'd0;
        foreach (m_wa[i]) e_mask[m_wa[i]] = 1'b1;
        e_count = 3'(m_wa.size());
    endfunction

    function automatic void model_edge();
        int sz;
        sz = m_wa.size();
        if (rst) begin
            m_wa.delete();
            m_wd.delete();
            m_wait = 0;
        end else begin
            if (e_bgrant) begin
                void'(m_wa.pop_front());
                void'(m_wd.pop_front());
            end
            if (b_valid && e_ready && b_wa != 5'd0) begin
                m_wa.push_back(b_wa);
                m_wd.push_back(b_wd);
            end
            if (sz == 0 || e_bgrant) m_wait = 0;
            else m_wait = m_wait + 1;
        end
    endfunction

    task automatic apply(input bit r, input bit awe, input logic [4:0] awa, input logic [31:0] awd,
                         input bit bv, input logic [4:0] bwa, input logic [31:0] bwd);
        rst = r; a_we = awe; a_wa = awa; a_wd = awd;
        b_valid = bv; b_wa = bwa; b_wd = bwd;
        model_outputs();
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1, 1, 5'd5, 32'h1234, 1, 5'd6, 32'h55);
        advance();
        apply(1, 1, 5'd5, 32'h1234, 1, 5'd6, 32'h55);
        checks++;
        if ({rf_we, b_ready, stall_a} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got we/ready/stall=%b expected 000", {rf_we, b_ready, stall_a});
        end
        checks++;
        if (b_count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", b_count);
        end
        checks++;
        if (pending_mask !== 32'd0) begin
            errors++; $display("FAIL reset_mask: got %h expected 0", pending_mask);
        end
        advance();
    endtask

    task automatic test_a_only();
        apply(0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        checks++;
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
            errors++; $display("FAIL a_write: got we=%b wa=%0d wd=%h expected 1 3 deadbeef", rf_we, rf_wa, rf_wd);
        end
        advance();
        apply(0, 1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        checks++;
        if ({rf_we, rf_wa, rf_wd, stall_a} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errors++; $display("FAIL a_reg0: got we=%b wa=%0d wd=%h stall=%b expected 0 0 0 0", rf_we, rf_wa, rf_wd, stall_a);
        end
        advance();
    endtask

    task automatic test_b_single();
        apply(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h11);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++; $display("FAIL b_ready_empty: got %b expected 1", b_ready);
        end
        advance();
        apply(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        checks++;
        if ({pending_mask, b_count} !== {32'h80, 3'd1}) begin
            errors++; $display("FAIL b_queued: got mask=%h count=%0d expected 80 1", pending_mask, b_count);
        end
        checks++;
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd7, 32'h11}) begin
            errors++; $display("FAIL b_write: got we=%b wa=%0d wd=%h expected 1 7 11", rf_we, rf_wa, rf_wd);
        end
        advance();
        apply(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        checks++;
        if ({pending_mask, b_count, rf_we} !== {32'h0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL b_popped: got mask=%h count=%0d we=%b expected 0 0 0", pending_mask, b_count, rf_we);
        end
        advance();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 5'(20 + i), 32'hA0 + i, 1, 5'(i + 1), 32'h100 + i);
            checks++;
            if ({rf_we, rf_wa} !== {1'b1, 5'(20 + i)}) begin
                errors++; $display("FAIL fill_a_write[%0d]: got we=%b wa=%0d expected 1 %0d", i, rf_we, rf_wa, 20 + i);
            end
            advance();
        end
        apply(0, 1, 5'd25, 32'hA5, 1, 5'd5, 32'h105);
        checks++;
        if ({b_ready, b_count, pending_mask} !== {1'b0, 3'd4, 32'h1E}) begin
            errors++; $display("FAIL fill_full: got ready=%b count=%0d mask=%h expected 0 4 1e", b_ready, b_count, pending_mask);
        end
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            checks++;
            if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'(i + 1), 32'h100 + i}) begin
                errors++; $display("FAIL drain_order[%0d]: got we=%b wa=%0d wd=%h expected 1 %0d %h", i, rf_we, rf_wa, rf_wd, i + 1, 32'h100 + i);
            end
            checks++;
            if ({b_ready, b_count} !== {(i != 0), 3'(4 - i)}) begin
                errors++; $display("FAIL drain_ready[%0d]: got ready=%b count=%0d expected %0d %0d", i, b_ready, b_count, (i != 0), 4 - i);
            end
            advance();
        end
    endtask

    task automatic test_a_priority();
        apply(0, 0, 5'd0, 32'd0, 1, 5'd10, 32'hAA);
        advance();
        apply(0, 1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
        checks++;
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h99}) begin
            errors++; $display("FAIL prio_a: got we=%b wa=%0d wd=%h expected 1 9 99", rf_we, rf_wa, rf_wd);
        end
        advance();
        apply(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        checks++;
        if ({b_count, rf_we, rf_wa, rf_wd} !== {3'd1, 1'b1, 5'd10, 32'hAA}) begin
            errors++; $display("FAIL prio_b_after: got count=%0d we=%b wa=%0d wd=%h expected 1 1 10 aa", b_count, rf_we, rf_wa, rf_wd);
        end
        advance();
    endtask

    task automatic test_starve();
        logic       exp_stall;
        logic [4:0] exp_wa;
        logic [2:0] exp_count;
        apply(0, 1, 5'd2, 32'h2, 1, 5'd12, 32'hC0DE);
        advance();
        for (int k = 1; k <= 10; k++) begin
            apply(0, 1, 5'(k + 1), 32'(k), 0, 5'd0, 32'd0);
`ifdef WB_STARVE_GUARD_EN
            exp_stall = (k == 9);
            exp_wa    = (k == 9) ? 5'd12 : 5'(k + 1);
`else
            exp_stall = 1'b0;
            exp_wa    = 5'(k + 1);
`endif
            checks++;
            if ({stall_a, rf_we, rf_wa} !== {exp_stall, 1'b1, exp_wa}) begin
                errors++; $display("FAIL starve[%0d]: got stall=%b we=%b wa=%0d expected %b 1 %0d", k, stall_a, rf_we, rf_wa, exp_stall, exp_wa);
            end
            advance();
        end
        apply(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
`ifdef WB_STARVE_GUARD_EN
        exp_count = 3'd0;
`else
        exp_count = 3'd1;
`endif
        checks++;
        if ({b_count, rf_we} !== {exp_count, exp_count[0]}) begin
            errors++; $display("FAIL starve_after: got count=%0d we=%b expected %0d %b", b_count, rf_we, exp_count, exp_count[0]);
        end
        advance();
    endtask

    task automatic test_random();
        int busy;
        for (int n = 0; n < 600; n++) begin
            case ((n / 100) % 4)
                0: busy = 90;
                1: busy = 40;
                2: busy = 100;
                default: busy = 10;
            endcase
            apply($urandom_range(0, 59) == 0, $urandom_range(1, 100) <= busy,
                  5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            checks++;
            if ({rf_we, rf_wa, rf_wd} !== {e_we, e_wa, e_wd}) begin
                errors++; $display("FAIL rand_port[%0d]: got we=%b wa=%0d wd=%h expected %b %0d %h", n, rf_we, rf_wa, rf_wd, e_we, e_wa, e_wd);
            end
            checks++;
            if ({stall_a, b_ready} !== {e_stall, e_ready}) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got stall=%b ready=%b expected %b %b", n, stall_a, b_ready, e_stall, e_ready);
            end
            checks++;
            if ({pending_mask, b_count} !== {e_mask, e_count}) begin
                errors++; $display("FAIL rand_queue[%0d]: got mask=%h count=%0d expected %h %0d", n, pending_mask, b_count, e_mask, e_count);
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; a_we = 1'b0; a_wa = '0; a_wd = '0;
        b_valid = 1'b0; b_wa = '0; b_wd = '0;
        @(negedge clk);
        test_reset();
        test_a_only();
        test_b_single();
        test_fill();
        test_a_priority();
        test_starve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
